// File: rtl/bisr_shift_ctrl.sv
// Stall / per-column shift-enable sequencer for the BISR weight-proxy remap path.
// Optional LOAD timeout is compiled in with `define BISR_SHIFT_CTRL_TIMEOUT_EN.
module bisr_shift_ctrl #(
    parameter int NUM_COLS     = 8,
    parameter int COL_W        = 3,
    parameter int CNT_W        = 8,
    parameter int LOAD_TIMEOUT = 64,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                remap_req,
    input  logic [COL_W-1:0]    remap_col,
    input  logic                clear_req,
    input  logic                weight_load_done,
    output logic                weight_load_start,
    output logic                stall,
    output logic [NUM_COLS-1:0] shift_en,
    output logic                remap_ack,
    output logic                active,
    output logic                busy,
    output logic                err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ALIGN,
        ACTIVE,
        DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
`ifdef BISR_SHIFT_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_TIMEOUT - 1);
`endif

    if ((1 << COL_W) < NUM_COLS) begin : g_bad_col_w
        $error("COL_W too narrow for NUM_COLS");
    end
    if (LOAD_TIMEOUT < 1 || LOAD_TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
        $error("LOAD_TIMEOUT must be in 1..2^CNT_W-1");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES >= (1 << CNT_W)) begin : g_bad_drain
        $error("DRAIN_CYCLES must be in 1..2^CNT_W-1");
    end

    state_t           state;
    logic [COL_W-1:0] col_q;
    logic [CNT_W-1:0] cnt;
    logic             col_valid;

    // Column i shifts when it is the faulty column or anywhere to its right.
    function automatic logic [NUM_COLS-1:0] thermo_mask(input logic [COL_W-1:0] c);
        logic [NUM_COLS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            m[i] = (i >= int'(c));
        end
        return m;
    endfunction

    assign col_valid = (int'(remap_col) < NUM_COLS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            col_q             <= '0;
            cnt               <= '0;
            weight_load_start <= 1'b0;
            stall             <= 1'b0;
            shift_en          <= '0;
            remap_ack         <= 1'b0;
            active            <= 1'b0;
            busy              <= 1'b0;
            err               <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make the pulse outputs one cycle wide;
            // a later assignment in the same block overrides them for this edge.
            weight_load_start <= 1'b0;
            remap_ack         <= 1'b0;
            err               <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (remap_req) begin
                        if (col_valid) begin
                            col_q             <= remap_col;
                            state             <= LOAD;
                            cnt               <= '0;
                            stall             <= 1'b1;
                            busy              <= 1'b1;
                            weight_load_start <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (weight_load_done) begin
                        state    <= ALIGN;
                        cnt      <= '0;
                        stall    <= 1'b0;
                        shift_en <= thermo_mask(col_q);
                    end
`ifdef BISR_SHIFT_CTRL_TIMEOUT_EN
                    else if (cnt == LOAD_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        stall <= 1'b0;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
`endif
                    else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ALIGN: begin
                    state     <= ACTIVE;
                    cnt       <= '0;
                    active    <= 1'b1;
                    remap_ack <= 1'b1;
                end

                ACTIVE: begin
                    if (clear_req) begin
                        state  <= DRAIN;
                        cnt    <= '0;
                        active <= 1'b0;
                        stall  <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        stall    <= 1'b0;
                        shift_en <= '0;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bisr_shift_ctrl.sv
// Self-checking bench for bisr_shift_ctrl: table-driven remaps, directed corner
// sequences and randomized traffic checked against a per-transaction timeline model.
module tb_bisr_shift_ctrl;

    localparam int NC = 8;
    localparam int CW = 4;
    localparam int CNTW = 8;
    localparam int LT = 64;
    localparam int DC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          remap_req;
    logic [CW-1:0] remap_col;
    logic          clear_req;
    logic          weight_load_done;
    logic          weight_load_start;
    logic          stall;
    logic [NC-1:0] shift_en;
    logic          remap_ack;
    logic          active;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    bisr_shift_ctrl #(
        .NUM_COLS(NC), .COL_W(CW), .CNT_W(CNTW), .LOAD_TIMEOUT(LT), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .remap_req(remap_req), .remap_col(remap_col), .clear_req(clear_req),
        .weight_load_done(weight_load_done), .weight_load_start(weight_load_start),
        .stall(stall), .shift_en(shift_en), .remap_ack(remap_ack),
        .active(active), .busy(busy), .err(err)
    );

    typedef struct {
        logic          stall;
        logic [NC-1:0] shift_en;
        logic          wls;
        logic          ack;
        logic          act;
        logic          busy;
        logic          err;
    } outs_t;

    typedef struct {
        int            col;
        int            load_cycles;
        int            active_cycles;
        logic [NC-1:0] exp_mask;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_cyc = -1;

    function automatic outs_t zero_o();
        outs_t o;
        o.stall = 1'b0; o.shift_en = '0; o.wls = 1'b0; o.ack = 1'b0;
        o.act = 1'b0; o.busy = 1'b0; o.err = 1'b0;
        return o;
    endfunction

    function automatic logic [13:0] pack(input outs_t o);
        return {o.stall, o.shift_en, o.wls, o.ack, o.act, o.busy, o.err};
    endfunction

    // Reference thermometer: all ones shifted left by the faulty column index.
    function automatic logic [NC-1:0] model_mask(input int col);
        logic [NC-1:0] ones;
        ones = '1;
        return ones << col;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs for the coming edge, then compare the
    // outputs present during this cycle against the model.
    task automatic cycle(input logic rq, input int col, input logic clr, input logic done,
                         input outs_t e, input string tag);
        outs_t g;
        @(posedge clk);
        #1;
        cyc++;
        remap_req = rq;
        remap_col = CW'(col);
        clear_req = clr;
        weight_load_done = done;
        @(negedge clk);
        if (remap_ack) ack_cyc = cyc;
        g.stall = stall; g.shift_en = shift_en; g.wls = weight_load_start; g.ack = remap_ack;
        g.act = active; g.busy = busy; g.err = err;
        check(tag, 32'(pack(g)), 32'(pack(e)));
    endtask

    function automatic logic rnd(input bit en);
        return en ? logic'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic idle_cycles(input int n, input bit noise);
        for (int j = 0; j < n; j++)
            cycle(1'b0, 0, rnd(noise), rnd(noise), zero_o(), "idle");
    endtask

    // Whole remap transaction as a timeline: request, d LOAD cycles (done in the
    // last), one ALIGN, a ACTIVE cycles (clear in the last), DC DRAIN cycles.
    task automatic run_txn(input int col, input int d, input int a, input bit noise,
                           input bit rq_on_clear, input logic [NC-1:0] mask);
        outs_t e;
        int    r;
        ack_cyc = -1;
        cycle(1'b1, col, 1'b0, 1'b0, zero_o(), "idle_req");
        r = cyc;
        for (int j = 1; j <= d; j++) begin
            e = zero_o(); e.stall = 1'b1; e.busy = 1'b1; e.wls = (j == 1);
            cycle(rnd(noise), $urandom_range(0, 15), rnd(noise), (j == d), e, "load");
        end
        e = zero_o(); e.busy = 1'b1; e.shift_en = mask;
        cycle(rnd(noise), $urandom_range(0, 15), rnd(noise), rnd(noise), e, "align");
        for (int j = 1; j <= a; j++) begin
            e = zero_o(); e.busy = 1'b1; e.shift_en = mask; e.act = 1'b1; e.ack = (j == 1);
            if (j == a)
                cycle(rq_on_clear, 1, 1'b1, rnd(noise), e, "active_clear");
            else
                cycle(rnd(noise), $urandom_range(0, 15), 1'b0, rnd(noise), e, "active");
        end
        for (int j = 1; j <= DC; j++) begin
            e = zero_o(); e.busy = 1'b1; e.shift_en = mask; e.stall = 1'b1;
            cycle(rnd(noise), $urandom_range(0, 15), rnd(noise), rnd(noise), e, "drain");
        end
        check("ack_latency", 32'(ack_cyc - r), 32'(d + 2));
    endtask

    task automatic bad_req(input int col);
        outs_t e;
        cycle(1'b1, col, 1'b0, 1'b0, zero_o(), "bad_req");
        e = zero_o(); e.err = 1'b1;
        cycle(1'b0, 0, 1'b0, 1'b0, e, "bad_err");
    endtask

    vec_t tbl[5];

    initial begin
        outs_t e;
        tbl[0] = '{col: 5, load_cycles: 3, active_cycles: 2, exp_mask: 8'hE0};
        tbl[1] = '{col: 0, load_cycles: 1, active_cycles: 3, exp_mask: 8'hFF};
        tbl[2] = '{col: 3, load_cycles: 2, active_cycles: 1, exp_mask: 8'hF8};
        tbl[3] = '{col: 7, load_cycles: 4, active_cycles: 2, exp_mask: 8'h80};
        tbl[4] = '{col: 1, load_cycles: 1, active_cycles: 1, exp_mask: 8'hFE};

        rst_n = 1'b0;
        remap_req = 1'b0; remap_col = '0; clear_req = 1'b0; weight_load_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              32'({stall, shift_en, weight_load_start, remap_ack, active, busy, err}), 32'd0);
        rst_n = 1'b1;
        idle_cycles(2, 1'b1);

        // Table vectors run back-to-back: each request lands in the first IDLE cycle.
        for (int i = 0; i < 5; i++)
            run_txn(tbl[i].col, tbl[i].load_cycles, tbl[i].active_cycles, 1'b0, 1'b0,
                    tbl[i].exp_mask);
        idle_cycles(2, 1'b0);

        bad_req(9);
        idle_cycles(1, 1'b0);
        bad_req(8);

        // remap_req coinciding with clear_req in ACTIVE is dropped silently.
        run_txn(3, 2, 3, 1'b0, 1'b1, 8'hF8);
        idle_cycles(3, 1'b0);

`ifdef BISR_SHIFT_CTRL_TIMEOUT_EN
        cycle(1'b1, 2, 1'b0, 1'b0, zero_o(), "to_req");
        for (int j = 1; j <= LT; j++) begin
            e = zero_o(); e.stall = 1'b1; e.busy = 1'b1; e.wls = (j == 1);
            cycle(1'b0, 0, 1'b0, 1'b0, e, "to_load");
        end
        e = zero_o(); e.err = 1'b1;
        cycle(1'b0, 0, 1'b0, 1'b0, e, "to_err");
        idle_cycles(2, 1'b0);
`else
        run_txn(2, LT + 40, 2, 1'b1, 1'b0, 8'hFC);
        idle_cycles(1, 1'b0);
`endif

        // Asynchronous reset during the first LOAD cycle.
        cycle(1'b1, 4, 1'b0, 1'b0, zero_o(), "rst_req");
        e = zero_o(); e.stall = 1'b1; e.busy = 1'b1; e.wls = 1'b1;
        cycle(1'b0, 0, 1'b0, 1'b0, e, "rst_load");
        #1 rst_n = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wls", 32'(weight_load_start), 32'd0);
        check("rst_shift_en", 32'(shift_en), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(1, 1'b0);
        run_txn(6, 2, 2, 1'b0, 1'b0, 8'hC0);
        idle_cycles(1, 1'b0);

        // Randomized traffic against the timeline model.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                bad_req($urandom_range(NC, 15));
            end else begin
                int c;
                c = $urandom_range(0, NC - 1);
                run_txn(c, $urandom_range(1, 12), $urandom_range(1, 6), 1'b1,
                        1'($urandom_range(0, 1)), model_mask(c));
            end
            idle_cycles($urandom_range(0, 2), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
